// File: rtl/rs_decoder.sv
// rtl/rs_decoder.sv - RS(7,5) single-symbol-correcting decoder over GF(8), one word per clock
//
// Purpose: computes the two syndromes of a received 21-bit codeword, locates
// and fixes a single symbol error, and registers the result with status flags.
// The whole syndrome/locate/correct path is combinational ahead of a single
// output register, so a new codeword is accepted on every clock.
//
// Ports:
//   clk              rising-edge clock
//   reset            asynchronous active-low reset; clears all outputs
//   codeword         received word, symbol j = bits [3j+2:3j] = coeff of x^j
//   corrected        registered corrected word (message [20:6], parity [5:0])
//   error_corrected  registered, a single-symbol error was fixed
//   uncorrectable    registered, a non-correctable pattern was seen

module rs_decoder #(
    parameter int N            = 7,
    parameter int K            = 5,
    parameter int SYMBOL_WIDTH = 3
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [N*SYMBOL_WIDTH-1:0]   codeword,
    output logic [N*SYMBOL_WIDTH-1:0]   corrected,
    output logic                        error_corrected,
    output logic                        uncorrectable
);

    localparam int W    = N * SYMBOL_WIDTH;
    localparam int NSYN = N - K;

    // Antilog table: alpha^k for k in 0..6, field polynomial x^3 + x + 1.
    function automatic logic [2:0] gf_exp(input logic [2:0] k);
        case (k)
            3'd0:    gf_exp = 3'd1;
            3'd1:    gf_exp = 3'd2;
            3'd2:    gf_exp = 3'd4;
            3'd3:    gf_exp = 3'd3;
            3'd4:    gf_exp = 3'd6;
            3'd5:    gf_exp = 3'd7;
            3'd6:    gf_exp = 3'd5;
            default: gf_exp = 3'd1;
        endcase
    endfunction

    // Log table; the value for 0 is a don't-care because callers guard zero.
    function automatic logic [2:0] gf_log(input logic [2:0] a);
        case (a)
            3'd1:    gf_log = 3'd0;
            3'd2:    gf_log = 3'd1;
            3'd4:    gf_log = 3'd2;
            3'd3:    gf_log = 3'd3;
            3'd6:    gf_log = 3'd4;
            3'd7:    gf_log = 3'd5;
            3'd5:    gf_log = 3'd6;
            default: gf_log = 3'd0;
        endcase
    endfunction

    // Exponent sum never exceeds 12, so one conditional subtract reduces mod 7.
    function automatic logic [2:0] gf_mul(input logic [2:0] a, input logic [2:0] b);
        logic [3:0] s;
        s = 4'(gf_log(a)) + 4'(gf_log(b));
        if (s >= 4'd7) s = s - 4'd7;
        if (a == 3'd0 || b == 3'd0) gf_mul = 3'd0;
        else                        gf_mul = gf_exp(s[2:0]);
    endfunction

    // Inverse of a nonzero element: alpha^(7 - log a) mod 7.
    function automatic logic [2:0] gf_inv(input logic [2:0] a);
        logic [2:0] l;
        l = gf_log(a);
        if (l == 3'd0) gf_inv = 3'd1;
        else           gf_inv = gf_exp(3'd7 - l);
    endfunction

    logic [2:0] sym [N];
    logic [2:0] syn [NSYN];
    logic [2:0] s1, s2;
    logic [2:0] loc;
    logic [2:0] mag;
    logic [W-1:0] fixed_word;
    logic [W-1:0] next_word;
    logic         next_corr;
    logic         next_unc;

    always_comb begin
        for (int j = 0; j < N; j++) begin
            sym[j] = codeword[SYMBOL_WIDTH*j +: SYMBOL_WIDTH];
        end
    end

    // Syndrome i (i = 0,1) evaluates the received polynomial at alpha^(i+1).
    always_comb begin
        for (int i = 0; i < NSYN; i++) begin
            syn[i] = 3'd0;
            for (int j = 0; j < N; j++) begin
                syn[i] = syn[i] ^ gf_mul(sym[j], gf_exp(3'(((i + 1) * j) % 7)));
            end
        end
    end

    assign s1 = syn[0];
    assign s2 = syn[1];

    // Single error of value e at position l gives S1 = e*a^l, S2 = e*a^2l,
    // so S2/S1 = a^l and S1^2/S2 = e.
    assign loc = gf_log(gf_mul(s2, gf_inv(s1)));
    assign mag = gf_mul(gf_mul(s1, s1), gf_inv(s2));

    always_comb begin
        fixed_word = codeword;
        for (int j = 0; j < N; j++) begin
            if (loc == 3'(j)) begin
                fixed_word[SYMBOL_WIDTH*j +: SYMBOL_WIDTH] = sym[j] ^ mag;
            end
        end
    end

    always_comb begin
        next_word = codeword;
        next_corr = 1'b0;
        next_unc  = 1'b0;
        if (s1 != 3'd0 && s2 != 3'd0) begin
            next_word = fixed_word;
            next_corr = 1'b1;
        end else if ((s1 == 3'd0) != (s2 == 3'd0)) begin
            next_unc  = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            corrected       <= '0;
            error_corrected <= 1'b0;
            uncorrectable   <= 1'b0;
        end else begin
            corrected       <= next_word;
            error_corrected <= next_corr;
            uncorrectable   <= next_unc;
        end
    end

endmodule

// File: tb/tb_rs_decoder.sv
// tb/tb_rs_decoder.sv - self-checking bench for rs_decoder

module tb_rs_decoder;

    logic        clk = 1'b0;
    logic        reset;
    logic [20:0] codeword;
    logic [20:0] corrected;
    logic        error_corrected;
    logic        uncorrectable;

    int vectors     = 0;
    int miscompares = 0;

    rs_decoder dut (
        .clk             (clk),
        .reset           (reset),
        .codeword        (codeword),
        .corrected       (corrected),
        .error_corrected (error_corrected),
        .uncorrectable   (uncorrectable)
    );

    always #5 clk = ~clk;

    // Carry-less polynomial product reduced by x^3 + x + 1.
    function automatic logic [2:0] ref_mul(input logic [2:0] a, input logic [2:0] b);
        logic [4:0] p;
        p = 5'd0;
        for (int i = 0; i < 3; i++) if (b[i]) p = p ^ (5'(a) << i);
        if (p[4]) p = p ^ 5'b10110;
        if (p[3]) p = p ^ 5'b01011;
        return p[2:0];
    endfunction

    // Systematic encoding: parity = m(x)*x^2 mod g(x), g(x) = x^2 + 6x + 3.
    function automatic logic [20:0] encode(input logic [14:0] msg);
        logic [2:0] r1, r0, fb;
        r1 = 3'd0;
        r0 = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            fb = msg[3*i +: 3] ^ r1;
            r1 = r0 ^ ref_mul(fb, 3'd6);
            r0 = ref_mul(fb, 3'd3);
        end
        return {msg, r1, r0};
    endfunction

    task automatic check(input string tag, input logic [22:0] obs, input logic [22:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed word=%h ec=%b unc=%b expected word=%h ec=%b unc=%b",
                   tag, obs[22:2], obs[1], obs[0], exp[22:2], exp[1], exp[0]);
        end
    endtask

    task automatic apply(input string tag, input logic [20:0] cw, input logic [22:0] exp);
        @(negedge clk);
        codeword = cw;
        @(posedge clk);
        #1;
        check(tag, {corrected, error_corrected, uncorrectable}, exp);
    endtask

    task automatic random_word(input string tag);
        logic [20:0] clean, rx;
        logic [2:0]  e;
        int          pos;
        logic        inj;
        clean = encode(15'($urandom));
        rx    = clean;
        inj   = ($urandom_range(0, 3) != 0);
        if (inj) begin
            pos = $urandom_range(0, 6);
            e   = 3'($urandom_range(1, 7));
            rx[3*pos +: 3] = rx[3*pos +: 3] ^ e;
        end
        apply(tag, rx, {clean, inj, 1'b0});
    endtask

    initial begin
        reset    = 1'b0;
        codeword = 21'h140073;
        @(posedge clk);
        @(posedge clk);
        #1;
        check("reset_hold", {corrected, error_corrected, uncorrectable}, 23'd0);

        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check("reset_release", {corrected, error_corrected, uncorrectable}, {21'h000073, 1'b1, 1'b0});

        apply("clean_g",       21'h000073, {21'h000073, 1'b0, 1'b0});
        apply("clean_zero",    21'h000000, {21'h000000, 1'b0, 1'b0});
        apply("msg_error",     21'h140073, {21'h000073, 1'b1, 1'b0});
        apply("parity_error",  21'h000070, {21'h000073, 1'b1, 1'b0});
        apply("uncorrectable", 21'h00000C, {21'h00000C, 1'b0, 1'b1});
        apply("encoder_ref",   encode(15'h0001), {21'h000073, 1'b0, 1'b0});

        for (int n = 0; n < 150; n++) random_word("stream_a");

        // Reset dropped between clock edges must clear outputs at once.
        apply("pre_reset", 21'h140073, {21'h000073, 1'b1, 1'b0});
        @(negedge clk);
        codeword = 21'h000070;
        reset    = 1'b0;
        #1;
        check("async_clear", {corrected, error_corrected, uncorrectable}, 23'd0);
        @(posedge clk);
        #1;
        check("reset_midstream_hold", {corrected, error_corrected, uncorrectable}, 23'd0);
        @(negedge clk);
        reset = 1'b1;

        for (int n = 0; n < 150; n++) random_word("stream_b");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
